// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier / accumulator datapath.
// Holds the accumulator FSM state encoding and the signed-add overflow test.
package booth_pkg;

  localparam int PROD_W_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Operands already sign-extended to a common width: overflow iff the two
  // operand signs agree and the sum sign disagrees with them.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/booth_mac_accum_if.sv
// Product-in / result-out handshake bundle for booth_mac_accum.
// master = producer/consumer side, slave = the accumulator block.
interface booth_mac_accum_if #(
    parameter int PROD_W = booth_pkg::PROD_W_DEF,
    parameter int ACC_W  = 16,
    parameter int N_MAX  = 16
);
    localparam int CNT_W = $clog2(N_MAX + 1);

    logic                     start;
    logic [CNT_W-1:0]         len;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod;
    logic                     acc_valid;
    logic                     acc_ready;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;
    logic                     busy;

    modport master (
        output start, len, prod_valid, prod, acc_ready,
        input  prod_ready, acc_valid, acc, ovf, busy
    );

    modport slave (
        input  start, len, prod_valid, prod, acc_ready,
        output prod_ready, acc_valid, acc, ovf, busy
    );
endinterface

// File: rtl/booth_acc_adder.sv
// Combinational accumulate step: sign-extend product, add, flag overflow.
// BOOTH_ACC_SAT_EN selects saturating instead of wrapping results.
module booth_acc_adder
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     ovf
);
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] raw;

    assign ext = ACC_W'(prod);
    assign raw = acc + ext;
    assign ovf = add_ovf(acc[ACC_W-1], ext[ACC_W-1], raw[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    // On overflow both operands share a sign, so acc's sign picks the rail.
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign sum = !ovf ? raw : (acc[ACC_W-1] ? SAT_MIN : SAT_MAX);
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/booth_mac_accum.sv
// Sums a programmed run of signed Booth products and hands the result downstream.
// Wrap vs. saturate is chosen by BOOTH_ACC_SAT_EN (see booth_acc_adder).
module booth_mac_accum
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = 16,
    parameter int N_MAX  = 16
) (
    input  logic               clk,
    input  logic               resetn,
    booth_mac_accum_if.slave   bus
);
    localparam int CNT_W = $clog2(N_MAX + 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic                    ovf_q, ovf_d, step_ovf;
    logic [CNT_W-1:0]        rem_q, rem_d, len_c;
    logic                    hs, launch;

    booth_acc_adder #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
        .acc  (acc_q),
        .prod (bus.prod),
        .sum  (sum),
        .ovf  (step_ovf)
    );

    assign len_c  = (bus.len > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : bus.len;
    assign hs     = bus.prod_valid && (state_q == ST_ACCUM);
    // A retiring result and a new start in the same cycle chain with no idle bubble.
    assign launch = bus.start && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_DONE) && bus.acc_ready));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: ;
            ST_ACCUM: begin
                if (hs) begin
                    acc_d = sum;
                    ovf_d = ovf_q | step_ovf;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.acc_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = len_c;
            state_d = (len_c == '0) ? ST_DONE : ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.prod_ready = (state_q == ST_ACCUM);
    assign bus.acc_valid  = (state_q == ST_DONE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.acc        = acc_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum with a result scoreboard.
// Build with or without BOOTH_ACC_SAT_EN; the reference model follows the same macro.
module tb_booth_mac_accum;
    localparam int N_MAX = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    booth_mac_accum_if #(.PROD_W(9), .ACC_W(16), .N_MAX(N_MAX)) bm ();
    booth_mac_accum_if #(.PROD_W(9), .ACC_W(10), .N_MAX(N_MAX)) bs ();

    booth_mac_accum #(.PROD_W(9), .ACC_W(16), .N_MAX(N_MAX)) u_main (
        .clk(clk), .resetn(resetn), .bus(bm.slave));
    booth_mac_accum #(.PROD_W(9), .ACC_W(10), .N_MAX(N_MAX)) u_narrow (
        .clk(clk), .resetn(resetn), .bus(bs.slave));

    typedef struct {
        int   acc;
        logic ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   v[N_MAX];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Range-based reference: out-of-range sum means overflow, then wrap or clamp.
    function automatic int model_add(input int w, input int a, input int p, inout logic o);
        int s  = a + p;
        int mx = (1 << (w - 1)) - 1;
        int mn = -(1 << (w - 1));
        if (s > mx || s < mn) begin
            o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
        end
        return s;
    endfunction

    task automatic run(input int len_in, input int n, input bit gaps, input bit b2b, input string tag);
        exp_t e;
        int   a = 0;
        logic o = 1'b0;
        bit   hs;
        int   guard;
        for (int i = 0; i < n; i++) a = model_add(16, a, v[i], o);
        e.acc = a;
        e.ovf = o;
        sb.push_back(e);
        bm.start = 1'b1;
        bm.len = 5'(len_in);
        bm.acc_ready = b2b;
        step();
        bm.start = 1'b0;
        bm.acc_ready = 1'b0;
        chk({tag, "_busy"}, bm.busy, 1);
        if (n == 0) begin
            chk({tag, "_len0_valid"}, bm.acc_valid, 1);
            chk({tag, "_len0_noready"}, bm.prod_ready, 0);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                bm.prod_valid = 1'b0;
                repeat ($urandom_range(0, 3)) step();
            end
            bm.prod = 9'(v[i]);
            bm.prod_valid = 1'b1;
            guard = 0;
            do begin
                hs = bm.prod_valid && bm.prod_ready;
                step();
                guard++;
            end while (!hs && guard < 50);
            if (!hs) chk({tag, "_hs_timeout"}, 0, 1);
        end
        if (n > 0) begin
            bm.prod_valid = 1'b0;
            chk({tag, "_latency"}, bm.acc_valid, 1);
        end
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int   guard = 0;
        while (!bm.acc_valid && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, "_valid"}, bm.acc_valid, 1);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
        else begin
            e = sb.pop_front();
            chk({tag, "_acc"}, bm.acc, e.acc);
            chk({tag, "_ovf"}, bm.ovf, e.ovf);
        end
    endtask

    task automatic retire(input string tag);
        bm.acc_ready = 1'b1;
        step();
        bm.acc_ready = 1'b0;
        chk({tag, "_retired"}, bm.acc_valid, 0);
        chk({tag, "_idle"}, bm.busy, 0);
    endtask

    initial begin
        int   a;
        logic o;
        bm.start = 0; bm.len = 0; bm.prod_valid = 0; bm.prod = 0; bm.acc_ready = 0;
        bs.start = 0; bs.len = 0; bs.prod_valid = 0; bs.prod = 0; bs.acc_ready = 0;
        repeat (2) step();
        chk("rst_prod_ready", bm.prod_ready, 0);
        chk("rst_acc_valid", bm.acc_valid, 0);
        chk("rst_acc", bm.acc, 0);
        chk("rst_ovf", bm.ovf, 0);
        chk("rst_busy", bm.busy, 0);
        resetn = 1'b1;
        step();

        // basic run, then hold the result with acc_ready low
        v[0] = 5; v[1] = -3; v[2] = 7; v[3] = 100;
        run(4, 4, 1'b0, 1'b0, "t1");
        collect("t1");
        bm.start = 1'b1; bm.len = 5'd1; bm.prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", bm.acc_valid, 1);
            chk("t2_hold_acc", bm.acc, 109);
            chk("t2_hold_noready", bm.prod_ready, 0);
        end
        bm.prod_valid = 1'b0;
        v[0] = 255;
        run(1, 1, 1'b0, 1'b1, "t2");
        collect("t2");
        retire("t2");

        // narrow accumulator overflow
        a = 0; o = 1'b0;
        for (int i = 0; i < 4; i++) a = model_add(10, a, 255, o);
        bs.start = 1'b1; bs.len = 5'd4; bs.prod = 9'sd255; bs.prod_valid = 1'b1;
        step();
        bs.start = 1'b0;
        repeat (4) step();
        bs.prod_valid = 1'b0;
        chk("t3_valid", bs.acc_valid, 1);
        chk("t3_acc", bs.acc, a);
        chk("t3_ovf", bs.ovf, o);
        bs.acc_ready = 1'b1;
        step();
        bs.acc_ready = 1'b0;

        // empty run
        bm.prod_valid = 1'b1; bm.prod = 9'd33;
        run(0, 0, 1'b0, 1'b0, "t4");
        collect("t4");
        bm.prod_valid = 1'b0;
        retire("t4");

        // reset mid-run
        bm.start = 1'b1; bm.len = 5'd4; bm.prod = 9'd10; bm.prod_valid = 1'b1;
        step();
        bm.start = 1'b0;
        repeat (2) step();
        #2 resetn = 1'b0;
        #1;
        chk("t5_rst_busy", bm.busy, 0);
        chk("t5_rst_acc", bm.acc, 0);
        chk("t5_rst_ready", bm.prod_ready, 0);
        chk("t5_rst_valid", bm.acc_valid, 0);
        bm.prod_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        v[0] = -256;
        run(1, 1, 1'b0, 1'b0, "t5");
        collect("t5");
        retire("t5");

        // idle products are never taken, then a full random run with gaps
        bm.prod_valid = 1'b1; bm.prod = 9'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_idle_noready", bm.prod_ready, 0);
            chk("t6_idle_busy", bm.busy, 0);
        end
        bm.prod_valid = 1'b0;
        for (int i = 0; i < N_MAX; i++) v[i] = int'($urandom_range(0, 511)) - 256;
        run(N_MAX, N_MAX, 1'b1, 1'b0, "t6");
        collect("t6");
        retire("t6");

        // len above N_MAX clamps to N_MAX
        for (int i = 0; i < N_MAX; i++) v[i] = int'($urandom_range(0, 511)) - 256;
        run(20, N_MAX, 1'b0, 1'b0, "t7");
        collect("t7");
        retire("t7");

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
